// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types, opcode classes and immediate decode for the fetch/decode front end
package riscv_pkg;

    // Widest supported XLEN; buffer entries always carry a PC this wide.
    localparam int XLEN_MAX = 64;

    // One-hot instruction format, ordered {r,i,s,b,u,j}.
    typedef logic [5:0] instr_type_t;

    localparam instr_type_t TYPE_NONE = 6'b000000;
    localparam instr_type_t TYPE_R    = 6'b100000;
    localparam instr_type_t TYPE_I    = 6'b010000;
    localparam instr_type_t TYPE_S    = 6'b001000;
    localparam instr_type_t TYPE_B    = 6'b000100;
    localparam instr_type_t TYPE_U    = 6'b000010;
    localparam instr_type_t TYPE_J    = 6'b000001;

    // opcode[6:2] class as a match/mask pair; a mask bit of 0 is a don't-care.
    typedef struct packed {
        logic [4:0] match;
        logic [4:0] mask;
    } opc_class_t;

    localparam opc_class_t CLS_R_OP   = '{match: 5'b01100, mask: 5'b11101}; // OP, OP-32
    localparam opc_class_t CLS_R_AMO  = '{match: 5'b01011, mask: 5'b11111}; // AMO
    localparam opc_class_t CLS_R_FP   = '{match: 5'b10100, mask: 5'b11111}; // OP-FP
    localparam opc_class_t CLS_I_LOAD = '{match: 5'b00000, mask: 5'b11110}; // LOAD, LOAD-FP
    localparam opc_class_t CLS_I_ALU  = '{match: 5'b00100, mask: 5'b11101}; // OP-IMM, OP-IMM-32
    localparam opc_class_t CLS_I_JALR = '{match: 5'b11001, mask: 5'b11111}; // JALR
    localparam opc_class_t CLS_S      = '{match: 5'b01000, mask: 5'b11110}; // STORE, STORE-FP
    localparam opc_class_t CLS_B      = '{match: 5'b11000, mask: 5'b11111}; // BRANCH
    localparam opc_class_t CLS_U      = '{match: 5'b00101, mask: 5'b10111}; // AUIPC, LUI
    localparam opc_class_t CLS_J      = '{match: 5'b11011, mask: 5'b11111}; // JAL

    // Buffered fetch result: the PC it was issued at plus the returned word.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [31:0]         instr;
    } fetch_entry_t;

    function automatic logic cls_hit(input logic [4:0] op5, input opc_class_t cls);
        return (op5 & cls.mask) == cls.match;
    endfunction

    // Map a 7-bit opcode to its one-hot format; TYPE_NONE means illegal.
    function automatic instr_type_t classify(input logic [6:0] opcode);
        instr_type_t t;
        t = TYPE_NONE;
        if (opcode[1:0] == 2'b11) begin
            if (cls_hit(opcode[6:2], CLS_R_OP) || cls_hit(opcode[6:2], CLS_R_AMO) ||
                cls_hit(opcode[6:2], CLS_R_FP)) begin
                t = TYPE_R;
            end else if (cls_hit(opcode[6:2], CLS_I_LOAD) || cls_hit(opcode[6:2], CLS_I_ALU) ||
                         cls_hit(opcode[6:2], CLS_I_JALR)) begin
                t = TYPE_I;
            end else if (cls_hit(opcode[6:2], CLS_S)) begin
                t = TYPE_S;
            end else if (cls_hit(opcode[6:2], CLS_B)) begin
                t = TYPE_B;
            end else if (cls_hit(opcode[6:2], CLS_U)) begin
                t = TYPE_U;
            end else if (cls_hit(opcode[6:2], CLS_J)) begin
                t = TYPE_J;
            end
        end
        return t;
    endfunction

    // Immediate sign-extended to XLEN_MAX; callers keep the low XLEN bits.
    // Only instr[31:7] carries immediate bits, so the opcode is not passed in.
    function automatic logic [XLEN_MAX-1:0] decode_imm(input logic [31:7] instr, input instr_type_t t);
        logic [XLEN_MAX-1:0] imm;
        case (t)
            TYPE_I:  imm = {{52{instr[31]}}, instr[31:20]};
            TYPE_S:  imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            TYPE_B:  imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            TYPE_U:  imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            TYPE_J:  imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/riscv_decode.sv
// rtl/riscv_decode.sv - combinational RV32I instruction field, format and immediate decoder
module riscv_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output instr_type_t     itype,
    output logic            illegal
);

    instr_type_t         cls;
    logic [XLEN_MAX-1:0] imm_full;
    logic                unused_imm_full;

    // Raw fields are always driven; format and immediate collapse to zero when illegal.
    always_comb begin
        opcode   = instr[6:0];
        rd       = instr[11:7];
        funct3   = instr[14:12];
        rs1      = instr[19:15];
        rs2      = instr[24:20];
        funct7   = instr[31:25];
        cls      = classify(instr[6:0]);
        imm_full = decode_imm(instr[31:7], cls);
        itype    = cls;
        illegal  = (cls == TYPE_NONE);
        imm      = imm_full[XLEN-1:0];
    end

    // Bits above XLEN are redundant sign copies when XLEN is narrower than XLEN_MAX.
    assign unused_imm_full = ^imm_full;

endmodule

// File: rtl/riscv_fetch_decode.sv
// rtl/riscv_fetch_decode.sv - PC owner, fixed-latency fetch, tagged decode buffer and decode output stage
module riscv_fetch_decode
    import riscv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     dec_instr,
    output logic [6:0]      dec_opcode,
    output logic [4:0]      dec_rd,
    output logic [2:0]      dec_funct3,
    output logic [4:0]      dec_rs1,
    output logic [4:0]      dec_rs2,
    output logic [6:0]      dec_funct7,
    output logic [XLEN-1:0] dec_imm,
    output logic [5:0]      dec_type,
    output logic            dec_illegal
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_LIM  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0]  PC_ALIGN   = ~(XLEN'(3));

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  tag_q, tag_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [FIFO_DEPTH];
    fetch_entry_t     mem_d [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic             fire;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     head;
    logic             unused_head_pc;

    // Handshake terms and fetch throttle: buffered + in flight - leaving must stay below depth.
    // Gating with reset keeps the request low while reset is held.
    always_comb begin
        dec_valid = (count_q != '0);
        pop       = dec_valid && dec_ready;
        push      = inflight_q && !redirect_valid;
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        fire      = reset && !redirect_valid && (occupancy < DEPTH_LIM);
        imem_req  = fire;
        imem_addr = pc_q;
    end

    // Next PC, in-flight flag and the PC tag that travels with the response.
    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = fire;
        if (redirect_valid) begin
            pc_d = redirect_pc & PC_ALIGN;
        end else if (fire) begin
            pc_d  = pc_q + PC_STEP;
            tag_d = pc_q;
        end
    end

    // Buffer update; a redirect discards both buffered entries and the pending response.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: XLEN_MAX'(tag_q), instr: imem_data};
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears the buffer and in-flight tracking without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    // Head entry reads as all zeros when empty so decode outputs stay deterministic.
    always_comb begin
        head   = dec_valid ? mem_q[rd_ptr_q] : '0;
        dec_pc = head.pc[XLEN-1:0];
    end

    // Entry PCs are stored at full width; the bits above XLEN are always zero.
    assign unused_head_pc = ^head.pc;
    assign dec_instr      = head.instr;

    riscv_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (head.instr),
        .opcode  (dec_opcode),
        .rd      (dec_rd),
        .funct3  (dec_funct3),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .funct7  (dec_funct7),
        .imm     (dec_imm),
        .itype   (dec_type),
        .illegal (dec_illegal)
    );

    // The issue throttle guarantees a response never lands on a full buffer.
    assert property (@(posedge clk) disable iff (!reset) !(push && (count_q == DEPTH_FULL)));

endmodule

// File: tb/tb_riscv_fetch_decode.sv
// tb/tb_riscv_fetch_decode.sv - directed self-checking bench for riscv_fetch_decode
module tb_riscv_fetch_decode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // XLEN=32 instance
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_funct3;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [6:0]  dec_funct7;
    logic [31:0] dec_imm;
    logic [5:0]  dec_type;
    logic        dec_illegal;

    // XLEN=64 instance
    logic        reset64;
    logic        imem_req64;
    logic [63:0] imem_addr64;
    logic [31:0] imem_data64;
    logic        redirect_valid64;
    logic [63:0] redirect_pc64;
    logic        dec_valid64;
    logic        dec_ready64;
    logic [63:0] dec_pc64;
    logic [31:0] dec_instr64;
    logic [6:0]  dec_opcode64;
    logic [4:0]  dec_rd64;
    logic [2:0]  dec_funct364;
    logic [4:0]  dec_rs164;
    logic [4:0]  dec_rs264;
    logic [6:0]  dec_funct764;
    logic [63:0] dec_imm64;
    logic [5:0]  dec_type64;
    logic        dec_illegal64;

    riscv_fetch_decode #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_funct3(dec_funct3), .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2), .dec_funct7(dec_funct7), .dec_imm(dec_imm), .dec_type(dec_type),
        .dec_illegal(dec_illegal)
    );

    riscv_fetch_decode #(.XLEN(64), .RESET_PC(64'h0), .FIFO_DEPTH(2)) u_dut64 (
        .clk(clk), .reset(reset64), .imem_req(imem_req64), .imem_addr(imem_addr64),
        .imem_data(imem_data64), .redirect_valid(redirect_valid64), .redirect_pc(redirect_pc64),
        .dec_valid(dec_valid64), .dec_ready(dec_ready64), .dec_pc(dec_pc64), .dec_instr(dec_instr64),
        .dec_opcode(dec_opcode64), .dec_rd(dec_rd64), .dec_funct3(dec_funct364), .dec_rs1(dec_rs164),
        .dec_rs2(dec_rs264), .dec_funct7(dec_funct764), .dec_imm(dec_imm64), .dec_type(dec_type64),
        .dec_illegal(dec_illegal64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset the 64-bit instance with a fixed memory word and stop at the first valid head.
    task automatic load64(input logic [31:0] ins);
        reset64     = 1'b0;
        imem_data64 = ins;
        @(posedge clk); #1;
        reset64 = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        reset            = 1'b0;
        dec_ready        = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        imem_data        = 32'h00500093;
        reset64          = 1'b0;
        dec_ready64      = 1'b0;
        redirect_valid64 = 1'b0;
        redirect_pc64    = 64'h0;
        imem_data64      = 32'h0;

        // Reset state: empty head decodes as all zeros (opcode 0 is illegal)
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",     imem_req,    0);
        chk("rst_addr",    imem_addr,   0);
        chk("rst_valid",   dec_valid,   0);
        chk("rst_pc",      dec_pc,      0);
        chk("rst_illegal", dec_illegal, 1);
        chk("rst_type",    dec_type,    0);
        chk("rst_imm",     dec_imm,     0);

        // Release: request in the same cycle, valid two cycles later, then 1/cycle
        reset = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("run_addr", imem_addr, 64'(4 * k));
            chk("run_req",  imem_req,  1);
            chk("run_valid", dec_valid, (k >= 2) ? 64'd1 : 64'd0);
            if (k >= 2) chk("run_pc", dec_pc, 64'(4 * (k - 2)));
            if (k == 2) begin
                chk("run_type", dec_type, 6'b010000);
                chk("run_imm",  dec_imm,  5);
                chk("run_rd",   dec_rd,   1);
                chk("run_ill",  dec_illegal, 0);
            end
            @(posedge clk); #1;
        end

        // Backpressure for 5 cycles: head holds at 16, fetch stops at depth
        dec_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req",   imem_req,  0);
            chk("bp_valid", dec_valid, 1);
            chk("bp_pc",    dec_pc,    32'h10);
            @(posedge clk); #1;
        end

        // Drain: in order, no gap, fetch resumes at 24
        dec_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k == 0) begin
                chk("dr_req",  imem_req,  1);
                chk("dr_addr", imem_addr, 32'h18);
            end
            chk("dr_valid", dec_valid, 1);
            chk("dr_pc",    dec_pc,    64'(16 + 4 * k));
            @(posedge clk); #1;
        end

        // Redirect to 0x103 with one buffered entry and one in flight
        dec_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        chk("rd_req0",   imem_req,  0);
        chk("rd_valid0", dec_valid, 1);
        chk("rd_pc0",    dec_pc,    32'h24);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        #1;
        chk("rd_addr1",  imem_addr, 32'h100);
        chk("rd_req1",   imem_req,  1);
        chk("rd_valid1", dec_valid, 0);
        @(posedge clk); #1;
        chk("rd_valid2", dec_valid, 0);
        chk("rd_addr2",  imem_addr, 32'h104);
        @(posedge clk); #1;
        chk("rd_valid3", dec_valid, 1);
        chk("rd_pc3",    dec_pc,    32'h100);
        @(posedge clk); #1;
        chk("rd_valid4", dec_valid, 1);
        chk("rd_pc4",    dec_pc,    32'h104);

        // Asynchronous reset mid-stream, then restart from RESET_PC
        reset = 1'b0;
        #1;
        chk("ar_valid", dec_valid, 0);
        chk("ar_req",   imem_req,  0);
        chk("ar_addr",  imem_addr, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("ar_req1",  imem_req,  1);
        chk("ar_addr1", imem_addr, 0);
        @(posedge clk); #1;
        chk("ar_addr2", imem_addr, 4);
        chk("ar_valid2", dec_valid, 0);
        @(posedge clk); #1;
        chk("ar_valid3", dec_valid, 1);
        chk("ar_pc3",    dec_pc,    0);

        // XLEN=64 immediate and format decode
        load64(32'hFE000FE3);
        chk("x64_beq_valid", dec_valid64, 1);
        chk("x64_beq_pc",    dec_pc64,    0);
        chk("x64_beq_type",  dec_type64,  6'b000100);
        chk("x64_beq_imm",   dec_imm64,   64'hFFFF_FFFF_FFFF_FFFE);

        load64(32'h800002B7);
        chk("x64_lui_type",  dec_type64,  6'b000010);
        chk("x64_lui_imm",   dec_imm64,   64'hFFFF_FFFF_8000_0000);
        chk("x64_lui_rd",    dec_rd64,    5);

        load64(32'h0080006F);
        chk("x64_jal_type",  dec_type64,  6'b000001);
        chk("x64_jal_imm",   dec_imm64,   8);

        load64(32'hFE512E23);
        chk("x64_sw_type",   dec_type64,  6'b001000);
        chk("x64_sw_imm",    dec_imm64,   64'hFFFF_FFFF_FFFF_FFFC);
        chk("x64_sw_rs2",    dec_rs264,   5);
        chk("x64_sw_rs1",    dec_rs164,   2);

        load64(32'h0000007F);
        chk("x64_ill_flag",   dec_illegal64, 1);
        chk("x64_ill_type",   dec_type64,    0);
        chk("x64_ill_imm",    dec_imm64,     0);
        chk("x64_ill_opcode", dec_opcode64,  7'h7F);

        load64(32'h00000033);
        chk("x64_add_type", dec_type64,    6'b100000);
        chk("x64_add_ill",  dec_illegal64, 0);
        chk("x64_add_imm",  dec_imm64,     0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_decode.md
Name: riscv_fetch_decode

Overview:
- Parametrised front end for the RV32I core: owns the PC, issues requests to a fixed-latency instruction memory, and buffers returned words in a small FIFO tagged with their PC.
- Decodes the FIFO head into fields, type flags and immediate, and presents it on a valid/ready interface to execute.
- Accepts a redirect (taken branch or jump) that flushes in-flight and buffered instructions.
- Adds, beyond the current PC+decode logic: backpressure, redirect/flush, XLEN and buffer-depth parameters, and illegal-opcode detection.

Parameters:
- XLEN, 32, PC and immediate width (32 or 64); the instruction word is always 32 bits.
- RESET_PC, 0, first fetch address after reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, decode buffer entries; power of two, at least 2.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address, equal to the current PC.
- imem_data  in  32  instruction word, valid exactly one cycle after imem_req.
- redirect_valid  in  1  load a new PC and flush.
- redirect_pc  in  XLEN  redirect target.
- dec_valid  out  1  decoded instruction available.
- dec_ready  in  1  consumer accepts; a transfer occurs when dec_valid && dec_ready.
- dec_pc  out  XLEN  PC of the head instruction.
- dec_instr  out  32  raw instruction word.
- dec_opcode  out  7  instr[6:0].
- dec_rd  out  5  instr[11:7].
- dec_funct3  out  3  instr[14:12].
- dec_rs1  out  5  instr[19:15].
- dec_rs2  out  5  instr[24:20].
- dec_funct7  out  7  instr[31:25].
- dec_imm  out  XLEN  sign-extended immediate.
- dec_type  out  6  one-hot {r,i,s,b,u,j}.
- dec_illegal  out  1  unrecognised opcode.

Behaviour:
- Reset asserted (reset=0):
  - pc=RESET_PC; FIFO empty; nothing in flight.
  - imem_req=0, imem_addr=RESET_PC, dec_valid=0.
  - All dec_* outputs are driven by decoding an empty head entry (all zeros).
- Fetch issue condition: fire = !redirect_valid && (count + inflight - pop) < FIFO_DEPTH, where pop = dec_valid && dec_ready.
  - imem_req=fire.
  - On fire: pc <= pc + 4, wrapping modulo 2^XLEN.
- First request occurs in the first clock edge's cycle after reset deasserts.
- inflight is a 1-bit flag set on fire and cleared the next cycle.
  - A response arriving with inflight=1 is pushed as {pc_tag, imem_data}.
  - pc_tag is the PC captured at issue.
- Latency: request in cycle N, push at the end of N+1, dec_valid=1 in N+2.
- Steady-state throughput is 1 instruction per cycle when dec_ready is held at 1.
- Redirect (redirect_valid=1):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; the low two bits are ignored.
  - The FIFO is cleared and inflight is cleared; any response due next cycle is dropped.
  - No request is issued this cycle.
  - dec_valid=0 from the next cycle; the first fetch of the target is issued the cycle after the redirect.
- Redirect has priority over a simultaneous pop and push; the pop still completes if dec_ready was high.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leave count unchanged.
  - A push while full cannot occur by construction; an assertion checks this.
  - dec_valid = (count != 0). The head is held stable while dec_valid && !dec_ready.
- Decode: combinational from the head entry, using opcode[6:2] classes:
  - r: 011x0, 01011, 10100.
  - i: 0000x, 001x0, 11001.
  - s: 0100x.
  - b: 11000.
  - u: 0x101.
  - j: 11011.
- Immediates (sign extension is from instr[31] to XLEN):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: sext({instr[31:12], 12'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R and illegal: 0.
- Illegal: dec_illegal=1 when opcode[1:0] != 2'b11 or no class matches. In that case dec_type=0 and dec_imm=0, but the raw fields are still driven.
- Reset asserted mid-operation clears all state immediately (asynchronously); in-flight data is lost.

Decomposition:
- Package riscv_pkg:
  - opcode class constants;
  - typedef instr_type_t (one-hot, 6 bits);
  - typedef fetch_entry_t {pc, instr};
  - function decode_imm().
- Sub-module riscv_decode: purely combinational instr -> fields, type, imm, illegal, parametrised by XLEN. It is instantiated once on the FIFO head.

Test Plan:
- Release reset with dec_ready=1 and memory returning 32'h00500093 (addi x1,x0,5) at every address. Required: imem_addr is 0, 4, 8, ... on consecutive cycles; the first dec_valid is 2 cycles after the first req, with dec_pc=0, dec_type=i, dec_imm=5, dec_rd=1; then one instruction per cycle.
- Backpressure: hold dec_ready=0 for 5 cycles. Required: imem_req stops after FIFO_DEPTH words are buffered or in flight; dec_pc is stable; releasing dec_ready drains the entries in order with no gap and no duplicate PC.
- Redirect to 32'h103 while the FIFO is full and a request is in flight. Required: the next imem_addr is 0x100; no stale dec_pc appears; dec_valid returns 2 cycles after the new request.
- Immediate decode with XLEN=64:
  - 32'hFE000FE3 (beq, offset -2): dec_type=b, dec_imm=64'hFFFF_FFFF_FFFF_FFFE.
  - 32'h800002B7 (lui): dec_imm=64'hFFFF_FFFF_8000_0000.
- 32'h0000007F: dec_illegal=1, dec_type=0, dec_imm=0. 32'h00000033 (add): dec_type=r, dec_illegal=0.
- Drive reset low mid-stream while dec_valid=1. Required: dec_valid=0 and imem_req=0 immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.
